// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; PreScale clocks per bit.
// Optional second stop bit (Two_Stop input) when UART_TX_TWO_STOP_EN is defined.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            PreScale,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  Two_Stop,
`endif
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned PS_W    = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PS_W-1:0]  MIN_PS   = PS_W'(4);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [PS_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PS_W-1:0]       ps_q, ps_d;
    logic                  two_stop_q, two_stop_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end_c;
    logic                  two_stop_in_c;

`ifdef UART_TX_TWO_STOP_EN
    assign two_stop_in_c = Two_Stop;
`else
    assign two_stop_in_c = 1'b0;
`endif

    assign bit_end_c = (cnt_q == (ps_q - PS_W'(1)));
    assign TX_OUT    = tx_q;
    assign Busy      = busy_q;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            ps_q       <= '0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            ps_q       <= ps_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, bit counter and bit index
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        ps_d       = ps_q;
        two_stop_d = two_stop_q;
        unique case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d    = START;
                    cnt_d      = '0;
                    idx_d      = '0;
                    data_d     = P_DATA;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    ps_d       = (PreScale < MIN_PS) ? MIN_PS : PreScale;
                    two_stop_d = two_stop_in_c;
                end
            end
            START: begin
                cnt_d = bit_end_c ? '0 : cnt_q + PS_W'(1);
                if (bit_end_c) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                cnt_d = bit_end_c ? '0 : cnt_q + PS_W'(1);
                if (bit_end_c) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                cnt_d = bit_end_c ? '0 : cnt_q + PS_W'(1);
                if (bit_end_c) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                cnt_d = bit_end_c ? '0 : cnt_q + PS_W'(1);
                // idx counts stop bits so the two-stop option reuses the same counters
                if (bit_end_c) begin
                    if (two_stop_q && (idx_q == '0)) begin
                        idx_d = IDX_W'(1);
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered line level and busy derived from the upcoming state
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[idx_d];
            PARITY:  tx_d = (^data_q) ^ par_typ_q;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer; the transmit-side counterpart of the oversampled UART receive path. It accepts a parallel byte through a valid/busy handshake and serialises it LSB-first as start, data, optional parity and stop bits. Each bit is held for PreScale clock cycles, so TX and RX share the same oversampled clock and PreScale setting. It sits between the system register interface and the TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- CLK  input  1  oversampled clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- P_DATA  input  DATA_WIDTH  parallel data to send.
- Data_Valid  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = parity bit included.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- PreScale  input  6  clock cycles per bit; legal range 4..63.
- TX_OUT  output  1  serial line, registered, idles high.
- Busy  output  1  frame in progress, registered.

Behaviour:
- Reset: the only reset is RST high, sampled on a CLK rising edge.
  - At the next edge: state IDLE, TX_OUT=1, Busy=0, all counters 0, latched data 0.
  - Reset mid-frame aborts the frame immediately. There is no partial stop bit.
- State machine: IDLE -> START -> DATA -> PARITY (only if latched PAR_EN=1) -> STOP -> IDLE.
- Accept: when Data_Valid=1 in IDLE (Busy=0) at edge E, the block latches P_DATA, PAR_EN, PAR_TYP and PreScale. After E:
  - state=START
  - TX_OUT=0
  - Busy=1
- Data_Valid while Busy=1 is ignored.
- Input changes after accept do not affect the frame in flight.
- Bit timing:
  - A cycle counter counts 0..PS-1, where PS is the latched PreScale.
  - Each bit is driven for exactly PS cycles.
  - A latched PreScale value below 4 is treated as 4.
- DATA state:
  - Bit index runs 0..DATA_WIDTH-1, LSB first.
  - The index increments at the counter wrap.
  - The state advances when index DATA_WIDTH-1 wraps.
- Parity: computed from the latched data.
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- STOP: TX_OUT=1 for PS cycles. At its final cycle the next edge moves the state to IDLE with Busy=0 and TX_OUT=1.
- Frame length: from the accept edge to the Busy-falling edge is (2+DATA_WIDTH+PAR_EN)*PS cycles.
- Minimum inter-frame gap: 1 IDLE cycle. Busy is low for at least one cycle between frames.
- TX_OUT is glitch-free: it is driven directly from a flop.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- When defined:
  - Extra input port Two_Stop (1 bit) is present and latched at accept.
  - If Two_Stop=1, STOP lasts 2*PS cycles and the frame length gains PS cycles.
- When undefined: the port is absent and there is always one stop bit.

Test Plan:
- Idle/reset: RST=1 for 2 cycles, then 0, with no Data_Valid -> TX_OUT=1 and Busy=0 continuously.
- Basic frame: PreScale=8, PAR_EN=0, P_DATA=0xA5, one-cycle Data_Valid.
  - TX_OUT = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles.
  - Busy high for exactly 80 cycles.
- Parity: PreScale=16, PAR_EN=1, P_DATA=0xA5.
  - PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1.
  - Busy high for 176 cycles.
- Handshake:
  - Data_Valid held high continuously with P_DATA=0x3C then 0xFF mid-frame -> first frame carries 0x3C.
  - Exactly one IDLE cycle, then the second frame carries the P_DATA present at that cycle.
- Reset mid-frame: assert RST during DATA bit 3 of a 0x00 frame -> next edge TX_OUT=1, Busy=0; a subsequent frame of 0x55 transmits correctly.
- Clamp/option:
  - PreScale=2 -> each bit is 4 cycles.
  - With UART_TX_TWO_STOP_EN and Two_Stop=1, PreScale=8, PAR_EN=0 -> stop high for 16 cycles, Busy 88 cycles.
